// File: rtl/sysid_info_slave.sv
// System-identification Avalon-MM slave: build identity words, a 64-bit uptime
// counter with coherent high-word snapshot, and a byte-writable scratch register.
module sysid_info_slave #(
  parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter logic [31:0] VERSION      = 32'h0000_0002,
  parameter logic [31:0] CLOCK_HZ     = 32'd50_000_000,
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000,
  parameter int unsigned ADDR_WIDTH   = 3,
  parameter logic [63:0] RESET_UPTIME = 64'h0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  input  logic [3:0]            byteenable,
  output logic [31:0]           readdata,
  output logic                  readdatavalid
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 64;
  localparam int unsigned LANES   = 4;
  localparam logic [31:0] MAGIC   = 32'h5359_5344;

  logic [CNT_W-1:0]      count;
  logic [DATA_W-1:0]     shadow;
  logic [DATA_W-1:0]     scratch;
  logic [ADDR_WIDTH-1:0] hi_c;
  logic [2:0]            word_c;
  logic                  mapped_c;
  logic                  wr_c;
  logic                  rd_up_c;
  logic                  clr_up_c;
  logic                  wr_scratch_c;
  logic [DATA_W-1:0]     rd_mux_c;

  // Word decode; a simultaneous read wins and the write is dropped.
  assign hi_c         = address >> 3;
  assign word_c       = address[2:0];
  assign mapped_c     = (hi_c == '0);
  assign wr_c         = write & ~read;
  assign rd_up_c      = read & mapped_c & (word_c == 3'd2);
  assign clr_up_c     = wr_c & mapped_c & (word_c == 3'd2);
  assign wr_scratch_c = wr_c & mapped_c & (word_c == 3'd4);

  always_comb begin
    rd_mux_c = '0;
    if (mapped_c) begin
      case (word_c)
        3'd0: rd_mux_c = SYSTEM_ID;
        3'd1: rd_mux_c = TIMESTAMP;
        3'd2: rd_mux_c = count[DATA_W-1:0];
        3'd3: rd_mux_c = shadow;
        3'd4: rd_mux_c = scratch;
        3'd5: rd_mux_c = VERSION;
        3'd6: rd_mux_c = CLOCK_HZ;
        3'd7: rd_mux_c = MAGIC;
      endcase
    end
  end

  // Free-running uptime; a write to word 2 restarts it from zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= RESET_UPTIME;
    end else if (clr_up_c) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // High word latched on the same edge the low word is read, so the pair is coherent.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
    end else if (rd_up_c) begin
      shadow <= count[CNT_W-1:DATA_W];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= SCRATCH_INIT;
    end else if (wr_scratch_c) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (byteenable[i]) scratch[8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

  // Fixed one-cycle read response; data holds between reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_mux_c;
    end
  end

endmodule

// File: tb/tb_sysid_info_slave.sv
// Bench for sysid_info_slave: behavioural register-map model compared every cycle,
// directed literal checks, randomized traffic, and a preset-uptime instance for wrap.
module tb_sysid_info_slave;

  localparam logic [31:0] SID   = 32'h5A7A_01CA;
  localparam logic [31:0] TS    = 32'h4C1E_2B00;
  localparam logic [31:0] VER   = 32'h0000_0002;
  localparam logic [31:0] CLK   = 32'd50_000_000;
  localparam logic [31:0] SINIT = 32'hA5A5_0F0F;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  logic        rst_w = 1'b0;
  logic [2:0]  w_addr = '0;
  logic        w_read = 1'b0;
  logic        w_write = 1'b0;
  logic [31:0] w_wdata = '0;
  logic [3:0]  w_be = '0;
  logic [31:0] w_rdata;
  logic        w_rdv;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  always #5 clock = ~clock;

  sysid_info_slave #(
    .SYSTEM_ID(SID), .TIMESTAMP(TS), .VERSION(VER), .CLOCK_HZ(CLK),
    .SCRATCH_INIT(SINIT), .ADDR_WIDTH(4), .RESET_UPTIME(64'h0)
  ) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .readdatavalid(readdatavalid)
  );

  sysid_info_slave #(
    .ADDR_WIDTH(3), .RESET_UPTIME(64'h0000_0000_FFFF_FFFF)
  ) dut_w (
    .clock(clock), .reset_n(rst_w), .address(w_addr), .read(w_read),
    .write(w_write), .writedata(w_wdata), .byteenable(w_be),
    .readdata(w_rdata), .readdatavalid(w_rdv)
  );

  // Behavioural model of the register map.
  logic [63:0] m_cnt;
  logic [31:0] m_shadow, m_scratch, m_rd;
  logic        m_rdv;

  function automatic logic [31:0] word_val(input logic [3:0] a);
    if (a >= 4'd8) return 32'h0;
    case (a)
      4'd0: return SID;
      4'd1: return TS;
      4'd2: return m_cnt[31:0];
      4'd3: return m_shadow;
      4'd4: return m_scratch;
      4'd5: return VER;
      4'd6: return CLK;
      default: return 32'h5359_5344;
    endcase
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt = 64'h0; m_shadow = 32'h0; m_scratch = SINIT; m_rd = 32'h0; m_rdv = 1'b0;
    end else begin
      m_rdv = read;
      if (read) begin
        m_rd = word_val(address);
        if (address == 4'd2) m_shadow = m_cnt[63:32];
      end
      if (write && !read && address == 4'd2) m_cnt = 64'h0;
      else m_cnt = m_cnt + 64'd1;
      if (write && !read && address == 4'd4)
        for (int b = 0; b < 4; b++)
          if (byteenable[b]) m_scratch[8*b +: 8] = writedata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (cmp_on) begin
      chk("model_rdv", 32'(readdatavalid), 32'(m_rdv));
      chk("model_rdata", readdata, m_rd);
    end
  end

  // Issue one read at the current negedge and check its response one edge later.
  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
    read = 1'b1; write = 1'b0; address = a;
    @(negedge clock);
    chk({name, "_rdv"}, 32'(readdatavalid), 32'd1);
    chk(name, readdata, exp);
    read = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    write = 1'b1; read = 1'b0; address = a; writedata = d; byteenable = be;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic idle(input int n);
    read = 1'b0; write = 1'b0;
    repeat (n) begin
      @(negedge clock);
      chk("idle_rdv", 32'(readdatavalid), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] held;
    repeat (3) @(negedge clock);
    chk("reset_rdata", readdata, 32'h0);
    chk("reset_rdv", 32'(readdatavalid), 32'd0);
    cmp_on = 1'b1;
    reset_n = 1'b1;

    // Uptime: first edge reads 0, ten edges later reads 10, clear restarts it.
    rd(4'd2, 32'd0, "uptime_first");
    idle(9);
    rd(4'd2, 32'd10, "uptime_10");
    wr(4'd2, 32'h1234_5678, 4'h0);
    rd(4'd2, 32'd0, "uptime_clear_edge");
    rd(4'd2, 32'd1, "uptime_after_clear");
    rd(4'd3, 32'd0, "shadow_zero");

    // Identity words.
    rd(4'd0, 32'h5A7A_01CA, "sysid");
    rd(4'd1, 32'h4C1E_2B00, "timestamp");
    rd(4'd5, 32'h0000_0002, "version");
    rd(4'd6, 32'h02FA_F080, "clock_hz");
    rd(4'd7, 32'h5359_5344, "magic");
    idle(1);

    // Scratch byte lanes.
    rd(4'd4, 32'hA5A5_0F0F, "scratch_init");
    wr(4'd4, 32'hDEAD_BEEF, 4'hF);
    wr(4'd4, 32'h0000_1234, 4'b0011);
    rd(4'd4, 32'hDEAD_1234, "scratch_lanes");
    wr(4'd4, 32'hFFFF_FFFF, 4'h0);
    rd(4'd4, 32'hDEAD_1234, "scratch_be0");
    wr(4'd4, 32'h0000_00AB, 4'h1);
    rd(4'd4, 32'hDEAD_12AB, "scratch_next_cycle");

    // Writes to read-only and unmapped words are ignored.
    wr(4'd0, 32'hFFFF_FFFF, 4'hF);
    wr(4'd7, 32'hFFFF_FFFF, 4'hF);
    wr(4'd9, 32'hFFFF_FFFF, 4'hF);
    rd(4'd0, 32'h5A7A_01CA, "ro_sysid");
    rd(4'd7, 32'h5359_5344, "ro_magic");

    // Back-to-back reads 0..8; model supplies the dynamic words.
    for (int a = 0; a <= 8; a++) rd(4'(a), word_val(4'(a)), $sformatf("b2b_%0d", a));
    idle(1);
    chk("hold_rdata", readdata, 32'h0);

    // Simultaneous read and write: read served, write dropped.
    read = 1'b1; write = 1'b1; address = 4'd4; writedata = 32'h0; byteenable = 4'hF;
    @(negedge clock);
    chk("rw_rdata", readdata, 32'hDEAD_12AB);
    read = 1'b0; write = 1'b0;
    rd(4'd4, 32'hDEAD_12AB, "rw_scratch_kept");

    // Reset just after a read edge clears outputs immediately.
    read = 1'b1; address = 4'd4;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_reset_rdv", 32'(readdatavalid), 32'd0);
    chk("mid_reset_rdata", readdata, 32'h0);
    read = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    idle(3);
    rd(4'd4, 32'hA5A5_0F0F, "scratch_after_reset");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      address = 4'($urandom_range(0, 15));
      read = ($urandom_range(0, 99) < 50);
      write = ($urandom_range(0, 99) < 35) && (address != 4'd2 || $urandom_range(0, 9) == 0);
      writedata = $urandom;
      byteenable = 4'($urandom);
      @(negedge clock);
    end
    read = 1'b0; write = 1'b0;
    held = m_rd;
    idle(2);
    chk("hold_after_random", readdata, held);

    // Preset instance: low word at all-ones, snapshot before and after carry.
    w_read = 1'b1; w_addr = 3'd2; rst_w = 1'b1;
    @(negedge clock);
    chk("wrap_rdv", 32'(w_rdv), 32'd1);
    chk("wrap_low", w_rdata, 32'hFFFF_FFFF);
    w_addr = 3'd3;
    @(negedge clock);
    chk("wrap_shadow_old", w_rdata, 32'h0);
    w_addr = 3'd2;
    @(negedge clock);
    chk("wrap_low_after", w_rdata, 32'h0000_0001);
    w_addr = 3'd3;
    @(negedge clock);
    chk("wrap_shadow_new", w_rdata, 32'h0000_0001);
    w_read = 1'b0;
    @(negedge clock);
    chk("wrap_rdv_drop", 32'(w_rdv), 32'd0);
    chk("wrap_hold", w_rdata, 32'h0000_0001);

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
